memory_model_pipe: RTL and testbench
====================================

// Module: memory_model_pipe
// PURPOSE
//   Parametrised pipelined main-memory model. Serves the core's mem_pkt_t request
//   stream with a configurable fixed latency and up to QUEUE_DEPTH requests in flight.
//   Adds honoured output backpressure, an error response and deterministic read data.
//   Sits behind the instruction/data ports as the simulation and FPGA backing store.
// PARAMETERS
//   DEPTH_WORDS  64  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//   LATENCY      2   cycles from the accept edge to the earliest pkt_out_vld; legal 1..15
//   QUEUE_DEPTH  4   maximum accepted-but-unconsumed responses; power of 2, >= 2
// PORTS
//   clk          in   1   clock
//   rst_n        in   1   reset, synchronous, active-low
//   pkt_in_vld   in   1   request valid
//   pkt_in_rdy   out  1   request ready
//   pkt_in       in   mem_pkt_t  request {mtype READ/WRITE, addr[31:0], len[3:0], data[31:0]}
//   pkt_out_vld  out  1   response valid
//   pkt_out_rdy  in   1   response ready
//   pkt_out      out  mem_pkt_t  response {mtype, addr, len copied from request; data}
//   pkt_out_err  out  1   response error flag; qualified by pkt_out_vld
// BEHAVIOUR
//   Reset: pkt_in_rdy=0, pkt_out_vld=0, pkt_out_err=0 and pkt_out=0 in the cycle after a
//     sampled rst_n=0. The response queue and the latency counters are flushed. Memory
//     contents are preserved across reset. Reset mid-operation drops all in-flight responses.
//   Accept: a request is accepted on a clock edge where pkt_in_vld && pkt_in_rdy.
//   pkt_in_rdy = rst_n_q && (occupancy < QUEUE_DEPTH).
//     - rst_n_q is the registered rst_n.
//     - occupancy counts queued responses and is held in a register.
//     - There is no combinational path from pkt_out_rdy to pkt_in_rdy.
//     - A pop and an accept in the same cycle leave occupancy unchanged.
//   len encoding: 0=word, 1=byte, 2=half. Values 3..15 are illegal.
//   Error when any of the following holds: illegal len; word access with addr[1:0]!=0;
//     half access with addr[0]!=0; addr[31:2] >= DEPTH_WORDS.
//     Error requests do not modify memory. Their response has err=1 and data=0.
//   Memory access happens at the accept edge, so requests are strictly ordered.
//   WRITE: byte lanes sel = {1111, 0001, 0011}[len] << addr[1:0] take
//     data << 8*addr[1:0]. Other lanes are unchanged. Response data=0.
//   READ: data = word >> 8*addr[1:0], masked to the access size.
//     Unused upper bytes are 0, never X.
//   Response queue: FIFO of QUEUE_DEPTH entries. Each entry carries {pkt, err, age}.
//     age starts at 1 on accept, increments each cycle and saturates at LATENCY.
//   pkt_out_vld = head valid && head.age == LATENCY. A response accepted at edge T is
//     presented at the earliest in the cycle after edge T+LATENCY-1, i.e. after LATENCY edges.
//   Once pkt_out_vld=1, pkt_out and pkt_out_err stay stable until pkt_out_rdy=1.
//     The pop happens on that edge. Entries behind the head keep ageing while the head stalls.
//   Back-to-back: with pkt_out_rdy held at 1 and QUEUE_DEPTH >= LATENCY+1, the block
//     sustains one request per cycle.
//   Read-pointer and write-pointer wrap-around at QUEUE_DEPTH is seamless.
//     full = occupancy == QUEUE_DEPTH; empty = occupancy == 0.
// TESTING
//   1. WRITE word 0xDEADBEEF @0x10, then READ word @0x10 (LATENCY=2)
//      -> read data 0xDEADBEEF, err=0; each pkt_out_vld exactly 2 edges after its accept.
//   2. WRITE byte 0xAA @0x13, READ word @0x10, READ half @0x12
//      -> 0xAAADBEEF, then 0x0000AAAD.
//   3. WRITE half @0x11, then READ word @0x10
//      -> first response err=1 data=0; the read returns 0xAAADBEEF (memory unchanged).
//   4. Hold pkt_out_rdy=0 and issue 6 reads
//      -> pkt_in_rdy=0 after 4 accepts; pkt_out held stable.
//      Raise pkt_out_rdy -> 4 responses in order, then the remaining 2 are accepted.
//   5. READ word @0x100 (DEPTH_WORDS=64) and a request with len=5
//      -> both responses err=1, data=0.
//   6. Issue 3 reads, pulse rst_n=0 for 1 cycle
//      -> pkt_out_vld=0 next cycle, no stale responses; a later READ @0x10 returns 0xAAADBEEF.

Source files
------------

// File: rtl/memory_model_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : memory_model_pipe
//  Brief    : Pipelined word memory model with fixed response latency, an
//             in-order response queue, output backpressure and error replies.
//  Revision : 1.0  initial release
// ============================================================================

package memory_model_pipe_pkg;
    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_type_e;

    typedef struct packed {
        mem_type_e   mtype;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
    } mem_pkt_t;
endpackage

module memory_model_pipe
    import memory_model_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     pkt_in_vld,
    output logic     pkt_in_rdy,
    input  mem_pkt_t pkt_in,
    output logic     pkt_out_vld,
    input  logic     pkt_out_rdy,
    output mem_pkt_t pkt_out,
    output logic     pkt_out_err
);

    localparam int         c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int         c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int         c_OCC_W = c_PTR_W + 1;
    localparam logic [3:0] c_LAT   = 4'(LATENCY);

    logic [31:0]        r_mem   [DEPTH_WORDS];
    mem_pkt_t           r_q_pkt [QUEUE_DEPTH];
    logic               r_q_err [QUEUE_DEPTH];
    logic [3:0]         r_q_age [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               r_rst_n_q;

    logic               w_acc;
    logic               w_pop;
    logic               w_head_vld;
    logic               w_in_range;
    logic               w_err;
    logic               w_is_write;
    logic [1:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [31:0]        w_rd_data;
    logic [3:0]         w_base;
    logic [3:0]         w_sel;
    logic [31:0]        w_wr_data;
    mem_pkt_t           w_resp;

    // Ready depends only on registered state, never on pkt_out_rdy.
    assign pkt_in_rdy = r_rst_n_q && (r_occ < c_OCC_W'(QUEUE_DEPTH));
    assign w_acc      = pkt_in_vld && pkt_in_rdy;
    assign w_head_vld = (r_occ != '0) && (r_q_age[r_rd_ptr] == c_LAT);
    assign w_pop      = w_head_vld && pkt_out_rdy;

    assign w_off      = pkt_in.addr[1:0];
    assign w_idx      = pkt_in.addr[c_IDX_W+1:2];
    assign w_in_range = pkt_in.addr[31:2] < 30'(DEPTH_WORDS);
    assign w_is_write = (pkt_in.mtype == MEM_WRITE);
    assign w_word     = w_in_range ? r_mem[w_idx] : '0;
    assign w_shift    = w_word >> {w_off, 3'b000};
    assign w_wr_data  = pkt_in.data << {w_off, 3'b000};
    assign w_sel      = w_base << w_off;

    always_comb begin
        w_err     = 1'b0;
        w_base    = 4'b0000;
        w_rd_data = '0;
        case (pkt_in.len)
            4'd0: begin
                w_base    = 4'b1111;
                w_rd_data = w_shift;
                w_err     = (w_off != 2'b00);
            end
            4'd1: begin
                w_base    = 4'b0001;
                w_rd_data = {24'h0, w_shift[7:0]};
            end
            4'd2: begin
                w_base    = 4'b0011;
                w_rd_data = {16'h0, w_shift[15:0]};
                w_err     = w_off[0];
            end
            default: w_err = 1'b1;
        endcase
        if (!w_in_range) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_resp       = pkt_in;
        w_resp.data  = (w_err || w_is_write) ? 32'h0 : w_rd_data;
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_acc && !w_err && w_is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rst_n_q <= rst_n;
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_age[i] <= '0;
            end
        end else begin
            // Every slot ages; a freshly written slot is restarted at 1 below.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (r_q_age[i] != c_LAT) begin
                    r_q_age[i] <= r_q_age[i] + 4'd1;
                end
            end
            if (w_acc) begin
                r_q_pkt[r_wr_ptr] <= w_resp;
                r_q_err[r_wr_ptr] <= w_err;
                r_q_age[r_wr_ptr] <= 4'd1;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_occ <= r_occ + c_OCC_W'(w_acc) - c_OCC_W'(w_pop);
        end
    end

    assign pkt_out_vld = w_head_vld;
    assign pkt_out     = w_head_vld ? r_q_pkt[r_rd_ptr] : '0;
    assign pkt_out_err = w_head_vld && r_q_err[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_memory_model_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_model_pipe
//  Brief    : Randomised and directed bench for memory_model_pipe against a
//             byte-addressed, time-stamped reference model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_memory_model_pipe;
    import memory_model_pipe_pkg::*;

    localparam int DEPTH_WORDS = 64;
    localparam int LATENCY     = 2;
    localparam int QUEUE_DEPTH = 4;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     pkt_in_vld = 1'b0;
    logic     pkt_in_rdy;
    mem_pkt_t pkt_in = '0;
    logic     pkt_out_vld;
    logic     pkt_out_rdy = 1'b0;
    mem_pkt_t pkt_out;
    logic     pkt_out_err;

    memory_model_pipe #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pkt_in_vld  (pkt_in_vld),
        .pkt_in_rdy  (pkt_in_rdy),
        .pkt_in      (pkt_in),
        .pkt_out_vld (pkt_out_vld),
        .pkt_out_rdy (pkt_out_rdy),
        .pkt_out     (pkt_out),
        .pkt_out_err (pkt_out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_pkt_t pkt;
        logic     err;
        int       edge_no;
    } exp_t;

    logic [7:0]  mem_b [4*DEPTH_WORDS];
    exp_t        exp_q [$];
    logic [31:0] pop_data [$];
    logic        pop_err [$];
    int          edges = 0;
    logic        known = 1'b0;
    logic        rst_q = 1'b0;
    logic        ordy_v = 1'b1;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mem_pkt_t mk(input mem_type_e t, input logic [31:0] a,
                                    input logic [3:0] l, input logic [31:0] d);
        mem_pkt_t p;
        p.mtype = t; p.addr = a; p.len = l; p.data = d;
        return p;
    endfunction

    // Reference: byte-addressed memory, access size derived from len.
    function automatic void model_req(input mem_pkt_t p, output mem_pkt_t r, output logic e);
        int sz;
        logic [31:0] d;
        sz = (p.len == 4'd0) ? 4 : (p.len == 4'd1) ? 1 : (p.len == 4'd2) ? 2 : 0;
        d  = '0;
        e  = (sz == 0) || (p.addr >= 32'(4*DEPTH_WORDS));
        if (!e && (p.addr % sz) != 0) e = 1'b1;
        if (!e) begin
            for (int i = 0; i < sz; i++) begin
                if (p.mtype == MEM_WRITE) mem_b[p.addr + i] = p.data[8*i +: 8];
                else                      d[8*i +: 8] = mem_b[p.addr + i];
            end
        end
        r = p;
        r.data = (e || p.mtype == MEM_WRITE) ? 32'h0 : d;
    endfunction

    // One clock: check outputs at the falling edge, drive inputs, advance model.
    task automatic cycle(input logic vld, input mem_pkt_t p, input logic ordy,
                         input logic rstn, output logic acc);
        logic exp_vld, exp_rdy;
        exp_t ent;
        @(negedge clk);
        exp_vld = (exp_q.size() > 0) && ((edges - exp_q[0].edge_no) >= LATENCY - 1);
        exp_rdy = rst_q && (exp_q.size() < QUEUE_DEPTH);
        if (known) begin
            check_value("out_vld", pkt_out_vld, exp_vld);
            check_value("in_rdy", pkt_in_rdy, exp_rdy);
            if (exp_vld) begin
                check_value("out_pkt", pkt_out, exp_q[0].pkt);
                check_value("out_err", pkt_out_err, exp_q[0].err);
            end
            if (!rst_q) begin
                check_value("rst_pkt_out", pkt_out, '0);
                check_value("rst_out_err", pkt_out_err, 1'b0);
            end
        end
        pkt_in_vld  = vld;
        pkt_in      = p;
        pkt_out_rdy = ordy;
        rst_n       = rstn;
        acc = known && vld && exp_rdy && rstn;
        if (!rstn) begin
            exp_q.delete();
            known = 1'b1;
        end else begin
            if (known && exp_vld && ordy) begin
                pop_data.push_back(pkt_out.data);
                pop_err.push_back(pkt_out_err);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                model_req(p, ent.pkt, ent.err);
                ent.edge_no = edges + 1;
                exp_q.push_back(ent);
            end
        end
        rst_q = rstn;
        @(posedge clk);
        edges++;
    endtask

    task automatic send(input mem_pkt_t p, input int max_cyc, output logic ok);
        logic a;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            cycle(1'b1, p, ordy_v, 1'b1, a);
            ok = a;
        end
    endtask

    task automatic send_chk(input mem_pkt_t p);
        logic ok;
        send(p, 40, ok);
        check_value("send_accept", ok, 1'b1);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b1, a);
        check_value("drain_left", exp_q.size(), 0);
    endtask

    task automatic clear_log();
        pop_data.delete();
        pop_err.delete();
    endtask

    initial begin
        logic a, ok;
        mem_pkt_t p;
        logic [31:0] d0, d1, d2;
        logic e0, e1;

        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, a);
        ordy_v = 1'b1;
        for (int w = 0; w < DEPTH_WORDS; w++) send_chk(mk(MEM_WRITE, 32'(4*w), 4'd0, $urandom));
        drain();

        // 1: word write then read
        clear_log();
        send_chk(mk(MEM_WRITE, 32'h10, 4'd0, 32'hDEADBEEF));
        send_chk(mk(MEM_READ,  32'h10, 4'd0, 32'h0));
        drain();
        d1 = pop_data[1]; e1 = pop_err[1];
        check_value("t1_read_data", d1, 32'hDEADBEEF);
        check_value("t1_read_err", e1, 1'b0);

        // 2: byte write then word and half reads
        clear_log();
        send_chk(mk(MEM_WRITE, 32'h13, 4'd1, 32'h000000AA));
        send_chk(mk(MEM_READ,  32'h10, 4'd0, 32'h0));
        send_chk(mk(MEM_READ,  32'h12, 4'd2, 32'h0));
        drain();
        d1 = pop_data[1]; d2 = pop_data[2];
        check_value("t2_word", d1, 32'hAAADBEEF);
        check_value("t2_half", d2, 32'h0000AAAD);

        // 3: misaligned half write is rejected
        clear_log();
        send_chk(mk(MEM_WRITE, 32'h11, 4'd2, 32'h00001234));
        send_chk(mk(MEM_READ,  32'h10, 4'd0, 32'h0));
        drain();
        d0 = pop_data[0]; e0 = pop_err[0]; d1 = pop_data[1];
        check_value("t3_err", e0, 1'b1);
        check_value("t3_err_data", d0, 32'h0);
        check_value("t3_unchanged", d1, 32'hAAADBEEF);

        // 4: backpressure fills the queue
        clear_log();
        ordy_v = 1'b0;
        for (int i = 0; i < 4; i++) send_chk(mk(MEM_READ, 32'(16 + 4*i), 4'd0, 32'h0));
        send(mk(MEM_READ, 32'h20, 4'd0, 32'h0), 6, ok);
        check_value("t4_blocked", ok, 1'b0);
        ordy_v = 1'b1;
        send_chk(mk(MEM_READ, 32'h20, 4'd0, 32'h0));
        send_chk(mk(MEM_READ, 32'h24, 4'd0, 32'h0));
        drain();
        check_value("t4_count", pop_data.size(), 6);

        // 5: out-of-range address and illegal len
        clear_log();
        send_chk(mk(MEM_READ, 32'h100, 4'd0, 32'h0));
        send_chk(mk(MEM_READ, 32'h10, 4'd5, 32'h0));
        drain();
        d0 = pop_data[0]; e0 = pop_err[0]; d1 = pop_data[1]; e1 = pop_err[1];
        check_value("t5_range_err", e0, 1'b1);
        check_value("t5_range_data", d0, 32'h0);
        check_value("t5_len_err", e1, 1'b1);
        check_value("t5_len_data", d1, 32'h0);

        // 6: reset drops in-flight responses, memory survives
        for (int i = 0; i < 3; i++) send_chk(mk(MEM_READ, 32'h10, 4'd0, 32'h0));
        cycle(1'b0, '0, 1'b1, 1'b0, a);
        clear_log();
        send_chk(mk(MEM_READ, 32'h10, 4'd0, 32'h0));
        drain();
        check_value("t6_count", pop_data.size(), 1);
        d0 = pop_data[0];
        check_value("t6_data", d0, 32'hAAADBEEF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic rstn, vld;
            rstn = ($urandom_range(0, 99) != 0);
            vld  = rstn && ($urandom_range(0, 3) != 0);
            p.mtype = mem_type_e'($urandom_range(0, 1));
            p.addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH_WORDS - 1));
            p.len   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            p.data  = $urandom;
            cycle(vld, p, ($urandom_range(0, 9) < 7), rstn, a);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
